// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 fetch stage.
package mips32_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Memory, redirect and decode-side signals of the fetch stage.
interface instruction_fetch_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] fetch_count;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output if_valid, if_instr, if_pc, if_pc_plus4, fetch_count,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  if_valid, if_instr, if_pc, if_pc_plus4, fetch_count,
    output if_ready
  );

endinterface

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register with next-PC select: reset, redirect, advance, hold.
module pc_reg
  import mips32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        advance_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = word_align(load_pc_i);
    end else if (advance_i) begin
      pc_d = pc_q + PC_STEP;
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem read, redirect squashing, decode handoff.
module instruction_fetch
  import mips32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [31:0]  pc;
  logic [31:0]  if_instr_q;
  logic [31:0]  if_pc_q;
  logic [31:0]  if_pc_plus4_q;
  logic [31:0]  fetch_count_q;
  logic         req_valid;
  logic         hold_valid;
  logic         latch_en;
  logic         consume;
  logic         pc_advance;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .load_i    (bus.redirect_valid),
    .load_pc_i (bus.redirect_pc),
    .advance_i (pc_advance),
    .pc_o      (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Any redirect also reloads pc inside pc_reg; here we only pick the state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (bus.imem_req_ready) begin
          state_d = bus.redirect_valid ? DRAIN : WAIT;
        end else begin
          state_d = FETCH;
        end
      end
      WAIT: begin
        if (bus.imem_resp_valid) begin
          state_d = bus.redirect_valid ? FETCH : HOLD;
        end else if (bus.redirect_valid) begin
          state_d = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      DRAIN: begin
        if (bus.imem_resp_valid) begin
          state_d = FETCH;
        end else begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (bus.if_ready || bus.redirect_valid) begin
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    req_valid  = (state_q == FETCH) && !reset;
    hold_valid = (state_q == HOLD);
    latch_en   = (state_q == WAIT) && bus.imem_resp_valid && !bus.redirect_valid;
    consume    = (state_q == HOLD) && bus.if_ready;
    pc_advance = consume && !bus.redirect_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_instr_q    <= NOP_INSTR;
      if_pc_q       <= 32'h0000_0000;
      if_pc_plus4_q <= 32'h0000_0000;
    end else if (latch_en) begin
      if_instr_q    <= bus.imem_resp_data;
      if_pc_q       <= pc;
      if_pc_plus4_q <= pc + PC_STEP;
    end else begin
      if_instr_q    <= if_instr_q;
      if_pc_q       <= if_pc_q;
      if_pc_plus4_q <= if_pc_plus4_q;
    end
  end

  // A consume coinciding with a redirect still counts as delivered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q <= 32'h0000_0000;
    end else if (consume) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end else begin
      fetch_count_q <= fetch_count_q;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.if_valid       = hold_valid;
  assign bus.if_instr       = if_instr_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_pc_plus4    = if_pc_plus4_q;
  assign bus.fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; inputs change and outputs are sampled on the falling edge.
module tb_instruction_fetch;

  logic clk;
  logic reset_a;
  logic reset_b;
  int   total;
  int   passed;

  instruction_fetch_if ifa ();
  instruction_fetch_if ifb ();

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (ifa)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    reset_a = 1'b1;
    reset_b = 1'b1;
    ifa.imem_req_ready = 1'b0; ifa.imem_resp_valid = 1'b0; ifa.imem_resp_data = 32'h0;
    ifa.redirect_valid = 1'b0; ifa.redirect_pc = 32'h0; ifa.if_ready = 1'b0;
    ifb.imem_req_ready = 1'b0; ifb.imem_resp_valid = 1'b0; ifb.imem_resp_data = 32'h0;
    ifb.redirect_valid = 1'b0; ifb.redirect_pc = 32'h0; ifb.if_ready = 1'b0;
    repeat (2) tick();

    chk("rst_req_valid", {31'd0, ifa.imem_req_valid}, 32'd0);
    chk("rst_if_valid", {31'd0, ifa.if_valid}, 32'd0);
    chk("rst_count", ifa.fetch_count, 32'd0);
    chk("rst_if_pc", ifa.if_pc, 32'd0);

    reset_a = 1'b0;
    tick();
    chk("first_req_valid", {31'd0, ifa.imem_req_valid}, 32'd1);
    chk("first_req_addr", ifa.imem_req_addr, 32'h0000_0000);

    // word 0 at 0x0, L = 1
    ifa.imem_req_ready = 1'b1; tick(); ifa.imem_req_ready = 1'b0;
    chk("wait_no_req", {31'd0, ifa.imem_req_valid}, 32'd0);
    ifa.imem_resp_valid = 1'b1; ifa.imem_resp_data = 32'h2001_0005; tick(); ifa.imem_resp_valid = 1'b0;
    chk("w0_if_valid", {31'd0, ifa.if_valid}, 32'd1);
    chk("w0_if_pc", ifa.if_pc, 32'h0000_0000);
    chk("w0_if_instr", ifa.if_instr, 32'h2001_0005);
    chk("w0_pc_plus4", ifa.if_pc_plus4, 32'h0000_0004);
    ifa.if_ready = 1'b1; tick(); ifa.if_ready = 1'b0;
    chk("w0_count", ifa.fetch_count, 32'd1);
    chk("w1_req_addr", ifa.imem_req_addr, 32'h0000_0004);
    chk("w1_req_valid", {31'd0, ifa.imem_req_valid}, 32'd1);
    chk("w0_consumed", {31'd0, ifa.if_valid}, 32'd0);

    // word 1 at 0x4, then a 4-cycle stall in HOLD
    ifa.imem_req_ready = 1'b1; tick(); ifa.imem_req_ready = 1'b0;
    ifa.imem_resp_valid = 1'b1; ifa.imem_resp_data = 32'h0000_0000; tick(); ifa.imem_resp_valid = 1'b0;
    chk("w1_if_pc", ifa.if_pc, 32'h0000_0004);
    chk("w1_if_instr", ifa.if_instr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_if_valid", {31'd0, ifa.if_valid}, 32'd1);
      chk("stall_if_pc", ifa.if_pc, 32'h0000_0004);
      chk("stall_req_valid", {31'd0, ifa.imem_req_valid}, 32'd0);
    end
    ifa.if_ready = 1'b1; tick(); ifa.if_ready = 1'b0;
    chk("w1_count", ifa.fetch_count, 32'd2);
    chk("w2_req_addr", ifa.imem_req_addr, 32'h0000_0008);

    // redirect to 0x40 while waiting, L = 3
    ifa.imem_req_ready = 1'b1; tick(); ifa.imem_req_ready = 1'b0;
    ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h0000_0040; tick(); ifa.redirect_valid = 1'b0;
    chk("drain_req_valid", {31'd0, ifa.imem_req_valid}, 32'd0);
    chk("drain_if_valid", {31'd0, ifa.if_valid}, 32'd0);
    tick();
    chk("drain2_req_valid", {31'd0, ifa.imem_req_valid}, 32'd0);
    ifa.imem_resp_valid = 1'b1; ifa.imem_resp_data = 32'hDEAD_BEEF; tick(); ifa.imem_resp_valid = 1'b0;
    chk("squash_if_valid", {31'd0, ifa.if_valid}, 32'd0);
    chk("redir_req_valid", {31'd0, ifa.imem_req_valid}, 32'd1);
    chk("redir_req_addr", ifa.imem_req_addr, 32'h0000_0040);

    // redirect to unaligned 0x43 together with the response
    ifa.imem_req_ready = 1'b1; tick(); ifa.imem_req_ready = 1'b0;
    ifa.imem_resp_valid = 1'b1; ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h0000_0043; tick();
    ifa.imem_resp_valid = 1'b0; ifa.redirect_valid = 1'b0;
    chk("coinc_req_valid", {31'd0, ifa.imem_req_valid}, 32'd1);
    chk("coinc_req_addr", ifa.imem_req_addr, 32'h0000_0040);
    chk("coinc_if_valid", {31'd0, ifa.if_valid}, 32'd0);

    // redirect in FETCH without acceptance, then with acceptance
    ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h0000_0300; tick(); ifa.redirect_valid = 1'b0;
    chk("fetch_redir_valid", {31'd0, ifa.imem_req_valid}, 32'd1);
    chk("fetch_redir_addr", ifa.imem_req_addr, 32'h0000_0300);
    ifa.imem_req_ready = 1'b1; ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h0000_0500; tick();
    ifa.imem_req_ready = 1'b0; ifa.redirect_valid = 1'b0;
    chk("fetch_acc_drain", {31'd0, ifa.imem_req_valid}, 32'd0);
    ifa.imem_resp_valid = 1'b1; tick(); ifa.imem_resp_valid = 1'b0;
    chk("fetch_acc_addr", ifa.imem_req_addr, 32'h0000_0500);
    chk("fetch_acc_if_valid", {31'd0, ifa.if_valid}, 32'd0);

    // redirect in HOLD without consume: dropped, not counted
    ifa.imem_req_ready = 1'b1; tick(); ifa.imem_req_ready = 1'b0;
    ifa.imem_resp_valid = 1'b1; ifa.imem_resp_data = 32'h1111_1111; tick(); ifa.imem_resp_valid = 1'b0;
    chk("w500_if_pc", ifa.if_pc, 32'h0000_0500);
    chk("w500_pc_plus4", ifa.if_pc_plus4, 32'h0000_0504);
    ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h0000_0100; tick(); ifa.redirect_valid = 1'b0;
    chk("drop_count", ifa.fetch_count, 32'd2);
    chk("drop_req_addr", ifa.imem_req_addr, 32'h0000_0100);
    chk("drop_if_valid", {31'd0, ifa.if_valid}, 32'd0);

    // consume together with redirect: counted, pc follows redirect
    ifa.imem_req_ready = 1'b1; tick(); ifa.imem_req_ready = 1'b0;
    ifa.imem_resp_valid = 1'b1; ifa.imem_resp_data = 32'h2222_2222; tick(); ifa.imem_resp_valid = 1'b0;
    chk("w100_if_pc", ifa.if_pc, 32'h0000_0100);
    ifa.if_ready = 1'b1; ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h0000_0200; tick();
    ifa.if_ready = 1'b0; ifa.redirect_valid = 1'b0;
    chk("cons_redir_count", ifa.fetch_count, 32'd3);
    chk("cons_redir_addr", ifa.imem_req_addr, 32'h0000_0200);

    // reset pulse mid-WAIT
    ifa.imem_req_ready = 1'b1; tick(); ifa.imem_req_ready = 1'b0;
    reset_a = 1'b1; #1;
    chk("mid_rst_req_valid", {31'd0, ifa.imem_req_valid}, 32'd0);
    chk("mid_rst_if_valid", {31'd0, ifa.if_valid}, 32'd0);
    chk("mid_rst_if_pc", ifa.if_pc, 32'd0);
    chk("mid_rst_if_instr", ifa.if_instr, 32'd0);
    chk("mid_rst_pc_plus4", ifa.if_pc_plus4, 32'd0);
    chk("mid_rst_count", ifa.fetch_count, 32'd0);
    tick();
    reset_a = 1'b0; #1;
    chk("post_rst_req_valid", {31'd0, ifa.imem_req_valid}, 32'd1);
    chk("post_rst_req_addr", ifa.imem_req_addr, 32'h0000_0000);

    // PC wraparound from RESET_PC = 0xFFFF_FFFC
    tick();
    reset_b = 1'b0;
    tick();
    chk("wrap_first_addr", ifb.imem_req_addr, 32'hFFFF_FFFC);
    ifb.imem_req_ready = 1'b1; tick(); ifb.imem_req_ready = 1'b0;
    ifb.imem_resp_valid = 1'b1; ifb.imem_resp_data = 32'h1234_5678; tick(); ifb.imem_resp_valid = 1'b0;
    chk("wrap_if_pc", ifb.if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", ifb.if_pc_plus4, 32'h0000_0000);
    chk("wrap_if_instr", ifb.if_instr, 32'h1234_5678);
    ifb.if_ready = 1'b1; tick(); ifb.if_ready = 1'b0;
    chk("wrap_next_addr", ifb.imem_req_addr, 32'h0000_0000);
    chk("wrap_count", ifb.fetch_count, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
